// File: rtl/sdram_init_seq.sv
// sdram_init_seq: parametrised SDRAM power-up initialisation sequencer.
// Sequence: power-up wait, PRECHARGE ALL, AREF_NUM x AUTO REFRESH, MODE REGISTER SET.
// A re-initialisation request in END reruns the sequence without the power-up wait.
// Optional build macro SDRAM_INIT_EMRS_EN adds an extended mode register set
// (EMRS, bank MSB set, address EMRS_VAL) after the MRS wait, for mobile SDRAM.
`timescale 1ns/1ps

module sdram_init_seq #(
  parameter int              ADDR_W     = 13,
  parameter int              BA_W       = 2,
  parameter int              WAIT_CYC   = 20000,
  parameter int              TRP_CYC    = 3,
  parameter int              TRFC_CYC   = 8,
  parameter int              TMRD_CYC   = 4,
  parameter int              AREF_NUM   = 8,
  parameter logic [2:0]      CAS_LAT    = 3'b011,
  parameter logic            BURST_TYPE = 1'b0,
  parameter logic [2:0]      BURST_LEN  = 3'b111,
  parameter logic            WR_BURST   = 1'b0
`ifdef SDRAM_INIT_EMRS_EN
  ,
  parameter logic [ADDR_W-1:0] EMRS_VAL = '0
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              reinit_req,
  output logic [3:0]        init_cmd,
  output logic [BA_W-1:0]   init_ba,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_end,
  output logic              init_busy
);

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_P_CHARGE  = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [3:0] CMD_M_REG_SET = 4'b0000;

  // Shared NOP-wait counter must hold the largest T*_CYC minus one.
  localparam int MAX_T  = (TRP_CYC > TRFC_CYC) ?
                          ((TRP_CYC > TMRD_CYC) ? TRP_CYC : TMRD_CYC) :
                          ((TRFC_CYC > TMRD_CYC) ? TRFC_CYC : TMRD_CYC);
  localparam int CNT_W  = (MAX_T < 2) ? 1 : $clog2(MAX_T + 1);
  localparam int PWR_W  = $clog2(WAIT_CYC + 1);

  localparam logic [PWR_W-1:0] PWR_LAST  = PWR_W'(WAIT_CYC - 1);
  localparam logic [PWR_W-1:0] PWR_MAX   = PWR_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'(TRP_CYC - 1);
  localparam logic [CNT_W-1:0] TRFC_LAST = CNT_W'(TRFC_CYC - 1);
  localparam logic [CNT_W-1:0] TMRD_LAST = CNT_W'(TMRD_CYC - 1);
  localparam logic [3:0]       AREF_LAST = 4'(AREF_NUM);

  // Mode register word: {reserved, write-burst mode, op mode, CAS latency, burst type, burst length}.
  localparam logic [12:0]       MODE13   = {3'b000, WR_BURST, 2'b00, CAS_LAT, BURST_TYPE, BURST_LEN};
  localparam logic [ADDR_W-1:0] MODE_VAL = ADDR_W'(MODE13);
`ifdef SDRAM_INIT_EMRS_EN
  localparam logic [BA_W-1:0]   EMRS_BA  = BA_W'(1) << (BA_W - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_TRP,
    S_AR,
    S_TRF,
    S_MRS,
    S_TMRD,
`ifdef SDRAM_INIT_EMRS_EN
    S_EMRS,
    S_TEMRD,
`endif
    S_END
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PWR_W-1:0]  pwr_cnt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [3:0]        aref_cnt;

  assign init_end  = (state == S_END);
  assign init_busy = (state != S_IDLE) && (state != S_END);

  // State register; reset always returns to IDLE so the full power-up wait repeats.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; reinit_req is only honoured in END and never remembered elsewhere.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (pwr_cnt == PWR_LAST) state_nxt = S_PRE;
      S_PRE:   state_nxt = S_TRP;
      S_TRP:   if (wait_cnt == TRP_LAST) state_nxt = S_AR;
      S_AR:    state_nxt = S_TRF;
      S_TRF:   if (wait_cnt == TRFC_LAST)
                 state_nxt = (aref_cnt == AREF_LAST) ? S_MRS : S_AR;
      S_MRS:   state_nxt = S_TMRD;
`ifdef SDRAM_INIT_EMRS_EN
      S_TMRD:  if (wait_cnt == TMRD_LAST) state_nxt = S_EMRS;
      S_EMRS:  state_nxt = S_TEMRD;
      S_TEMRD: if (wait_cnt == TMRD_LAST) state_nxt = S_END;
`else
      S_TMRD:  if (wait_cnt == TMRD_LAST) state_nxt = S_END;
`endif
      S_END:   if (reinit_req) state_nxt = S_PRE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Power-up counter runs only in IDLE and saturates so it cannot wrap back into a match.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                                     pwr_cnt <= '0;
    else if (state == S_IDLE && pwr_cnt != PWR_MAX)  pwr_cnt <= pwr_cnt + 1'b1;
  end

  // Shared NOP-wait counter restarts at every state change and counts while a sequence is active.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                 wait_cnt <= '0;
    else if (state_nxt != state) wait_cnt <= '0;
    else if (init_busy)          wait_cnt <= wait_cnt + 1'b1;
  end

  // Refresh counter restarts on entry to PRE and counts each AUTO REFRESH issued.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                                  aref_cnt <= '0;
    else if (state != S_PRE && state_nxt == S_PRE) aref_cnt <= '0;
    else if (state == S_AR)                        aref_cnt <= aref_cnt + 1'b1;
  end

  // Registered command/bank/address outputs, one clock behind the state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      init_cmd  <= CMD_NOP;
      init_ba   <= '1;
      init_addr <= '1;
    end else begin
      init_cmd  <= CMD_NOP;
      init_ba   <= '1;
      init_addr <= '1;
      case (state)
        S_PRE: init_cmd <= CMD_P_CHARGE;
        S_AR:  init_cmd <= CMD_AUTO_REF;
        S_MRS: begin
          init_cmd  <= CMD_M_REG_SET;
          init_ba   <= '0;
          init_addr <= MODE_VAL;
        end
`ifdef SDRAM_INIT_EMRS_EN
        S_EMRS: begin
          init_cmd  <= CMD_M_REG_SET;
          init_ba   <= EMRS_BA;
          init_addr <= EMRS_VAL;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
